// File: rtl/detector_sched_if.sv
// rtl/detector_sched_if.sv - request/result/detector signal bundle for detector_sched
interface detector_sched_if #(
    parameter int NREQ   = 2,
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4,
    parameter int ID_W   = 1
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*WORD_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   det_x;
    logic                   det_reset;
    logic                   det_z;
    logic                   res_valid;
    logic                   res_ready;
    logic [ID_W-1:0]        res_id;
    logic [CNT_W-1:0]       res_count;
    logic                   res_hit;
    logic                   busy;

    // Producers, result consumer and the detector itself sit on the master side
    modport master (
        output req_valid, req_data, det_z, res_ready,
        input  req_ready, det_x, det_reset, res_valid, res_id, res_count, res_hit, busy
    );

    // The scheduler sits on the slave side
    modport slave (
        input  req_valid, req_data, det_z, res_ready,
        output req_ready, det_x, det_reset, res_valid, res_id, res_count, res_hit, busy
    );
endinterface

// File: rtl/detector_sched.sv
// rtl/detector_sched.sv - round-robin sharing of one serial sequence detector
module detector_sched #(
    parameter int NREQ   = 2,
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4,
    parameter int ID_W   = 1
) (
    input  logic             clk,
    input  logic             reset,
    detector_sched_if.slave  bus
);
    localparam int BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);

    if ((2 ** CNT_W) <= WORD_W) begin : g_cnt_w_check
        $error("detector_sched: CNT_W too narrow for WORD_W");
    end
    if ((2 ** ID_W) < NREQ) begin : g_id_w_check
        $error("detector_sched: ID_W too narrow for NREQ");
    end
    if (NREQ < 2 || NREQ > 8) begin : g_nreq_check
        $error("detector_sched: NREQ must be 2..8");
    end

    typedef enum logic [1:0] {IDLE, FLUSH, SHIFT, RESULT} state_t;

    state_t             state_q;
    logic [ID_W-1:0]    last_grant_q;
    logic [ID_W-1:0]    id_q;
    logic [WORD_W-1:0]  shreg_q;
    logic [CNT_W-1:0]   count_q;
    logic [BC_W-1:0]    bitcnt_q;
    logic               res_valid_q;

    logic               grant_found;
    logic [ID_W-1:0]    grant_id;
    logic [WORD_W-1:0]  grant_word;

    // Round-robin search starting just after the last granted requester
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant_q) + k) % NREQ;
            if (!grant_found && bus.req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
        grant_word = bus.req_data[int'(grant_id)*WORD_W +: WORD_W];
    end

    // Grant only while idle; reset suppresses any accept on that edge
    assign bus.req_ready = (state_q == IDLE && grant_found && !reset)
                         ? (NREQ'(1) << grant_id) : '0;

    // The detector is cleared by block reset and by the per-word flush cycle
    assign bus.det_reset = reset || (state_q == FLUSH);
    assign bus.det_x     = (state_q == SHIFT) ? shreg_q[WORD_W-1] : 1'b0;
    assign bus.busy      = (state_q != IDLE);
    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = id_q;
    assign bus.res_count = count_q;
    assign bus.res_hit   = (count_q != '0);

    // Scheduler FSM: accept, flush detector, shift word MSB-first, hold result
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NREQ - 1);
            id_q         <= '0;
            shreg_q      <= '0;
            count_q      <= '0;
            bitcnt_q     <= '0;
            res_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        shreg_q      <= grant_word;
                        id_q         <= grant_id;
                        last_grant_q <= grant_id;
                        count_q      <= '0;
                        state_q      <= FLUSH;
                    end
                end
                FLUSH: begin
                    bitcnt_q <= '0;
                    state_q  <= SHIFT;
                end
                SHIFT: begin
                    if (bus.det_z && count_q != '1) begin
                        count_q <= count_q + CNT_W'(1);
                    end
                    shreg_q  <= {shreg_q[WORD_W-2:0], 1'b0};
                    bitcnt_q <= bitcnt_q + BC_W'(1);
                    if (bitcnt_q == LAST_BIT) begin
                        state_q     <= RESULT;
                        res_valid_q <= 1'b1;
                    end
                end
                RESULT: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_detector_sched.sv
// tb/tb_detector_sched.sv - directed self-checking bench for detector_sched
module tb_detector_sched;
    localparam int NREQ = 2, WORD_W = 8, CNT_W = 4, ID_W = 1;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    detector_sched_if #(.NREQ(NREQ), .WORD_W(WORD_W), .CNT_W(CNT_W), .ID_W(ID_W)) bus ();

    detector_sched #(.NREQ(NREQ), .WORD_W(WORD_W), .CNT_W(CNT_W), .ID_W(ID_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Overlapping 1011 detector, Mealy output, synchronous reset
    logic [1:0] det_st;
    assign bus.det_z = (det_st == 2'd3) && bus.det_x;
    always @(posedge clk) begin
        if (bus.det_reset) det_st <= 2'd0;
        else begin
            case (det_st)
                2'd0: det_st <= bus.det_x ? 2'd1 : 2'd0;
                2'd1: det_st <= bus.det_x ? 2'd1 : 2'd2;
                2'd2: det_st <= bus.det_x ? 2'd3 : 2'd0;
                default: det_st <= bus.det_x ? 2'd1 : 2'd2;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Submit one word from requester r with res_ready high; starts and ends in IDLE at a negedge
    task automatic do_word(input int r, input logic [7:0] w, input int exp_cnt);
        logic [7:0] wv;
        wv = w;
        bus.req_valid = '0;
        bus.req_valid[r] = 1'b1;
        bus.req_data[r*WORD_W +: WORD_W] = w;
        bus.res_ready = 1'b1;
        #1;
        check("grant", 32'(bus.req_ready), 32'(1 << r));
        check("idle_busy", 32'(bus.busy), 0);
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        check("flush_det_reset", 32'(bus.det_reset), 1);
        check("flush_det_x", 32'(bus.det_x), 0);
        check("flush_ready", 32'(bus.req_ready), 0);
        for (int i = 0; i < WORD_W; i++) begin
            @(negedge clk);
            #1;
            check("shift_x", 32'(bus.det_x), 32'(wv[WORD_W-1-i]));
            check("shift_no_res", 32'(bus.res_valid), 0);
        end
        @(negedge clk);
        #1;
        check("res_valid", 32'(bus.res_valid), 1);
        check("res_id", 32'(bus.res_id), 32'(r));
        check("res_count", 32'(bus.res_count), 32'(exp_cnt));
        check("res_hit", 32'(bus.res_hit), 32'(exp_cnt != 0));
        @(negedge clk);
        #1;
        check("back_idle", 32'(bus.busy), 0);
    endtask

    initial begin
        int order [4];
        order = '{0, 1, 0, 1};
        reset = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.res_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_res_valid", 32'(bus.res_valid), 0);
        check("rst_ready", 32'(bus.req_ready), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_det_reset", 32'(bus.det_reset), 1);
        check("rst_det_x", 32'(bus.det_x), 0);
        check("rst_res_id", 32'(bus.res_id), 0);
        check("rst_res_count", 32'(bus.res_count), 0);
        reset = 1'b0;
        @(negedge clk);

        // Basic word, zero word, and flush across a would-be boundary match
        do_word(0, 8'b1011_0110, 2);
        do_word(1, 8'h00, 0);
        do_word(0, 8'b0000_0101, 0);
        do_word(1, 8'b1100_0000, 0);

        // Back-to-back with both requesters pending: grants every 11 cycles, alternating
        bus.req_valid = 2'b11;
        bus.req_data  = {8'h5A, 8'hA5};
        bus.res_ready = 1'b1;
        for (int c = 0; c < 44; c++) begin
            #1;
            check("b2b_ready", 32'(bus.req_ready), (c % 11 == 0) ? 32'(1 << order[c / 11]) : 0);
            check("b2b_busy", 32'(bus.busy), (c % 11 == 0) ? 0 : 1);
            @(negedge clk);
        end
        bus.req_valid = '0;
        @(negedge clk);

        // Result held under backpressure, pending requester 1 not granted meanwhile
        bus.res_ready = 1'b0;
        bus.req_valid = 2'b01;
        bus.req_data  = {8'h0B, 8'b1011_0110};
        #1;
        check("hold_grant", 32'(bus.req_ready), 1);
        @(negedge clk);
        bus.req_valid = 2'b10;
        for (int i = 0; i < 9; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("hold_valid", 32'(bus.res_valid), 1);
            check("hold_id", 32'(bus.res_id), 0);
            check("hold_count", 32'(bus.res_count), 2);
            check("hold_ready", 32'(bus.req_ready), 0);
            @(negedge clk);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        #1;
        check("hold_next_grant", 32'(bus.req_ready), 2);
        @(negedge clk);
        bus.req_valid = '0;
        for (int i = 0; i < 9; i++) @(negedge clk);
        #1;
        check("r1_valid", 32'(bus.res_valid), 1);
        check("r1_id", 32'(bus.res_id), 1);
        check("r1_count", 32'(bus.res_count), 1);
        @(negedge clk);

        // Reset during the 4th SHIFT cycle aborts the word and rewinds the pointer
        bus.req_valid = 2'b01;
        bus.req_data  = {8'h00, 8'hFF};
        #1;
        check("abort_grant", 32'(bus.req_ready), 1);
        @(negedge clk);
        bus.req_valid = '0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_det_reset", 32'(bus.det_reset), 1);
        @(negedge clk);
        reset = 1'b0;
        bus.req_valid = 2'b11;
        #1;
        check("abort_no_res", 32'(bus.res_valid), 0);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_rr", 32'(bus.req_ready), 1);
        @(negedge clk);
        bus.req_valid = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            check("abort_shift_no_res", 32'(bus.res_valid), 0);
        end
        @(negedge clk);
        #1;
        check("abort_res_valid", 32'(bus.res_valid), 1);
        check("abort_res_id", 32'(bus.res_id), 0);
        check("abort_res_count", 32'(bus.res_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
